io_req_arb: RTL and testbench

IO_REQ_ARB -- requirements
Module: io_req_arb

---
 rtl/io_pkg.sv | 34 +++
 rtl/io_rr_pick.sv | 29 ++
 rtl/io_req_arb.sv | 170 +++++++++++++++++
 tb/tb_io_req_arb.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the I/O request arbiter (io_req_arb, io_rr_pick).
package io_pkg;

    typedef enum logic [2:0] {StIdle, StIssue, StWaitb, StBusy, StDone} io_state_t;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnAts  = 2'd1,
        OwnCpu  = 2'd2,
        OwnKey  = 2'd3
    } io_owner_t;

    localparam logic [3:0] ATS_CODE    = 4'b1111;
    localparam logic [1:0] WAITB_LIMIT = 2'd2;

    // Bit positions of the one-hot grant vector
    localparam int unsigned GNT_ATS = 0;
    localparam int unsigned GNT_CPU = 1;
    localparam int unsigned GNT_KEY = 2;

    function automatic io_owner_t owner_of(input logic [2:0] gnt);
        io_owner_t own;
        own = OwnNone;
        if (gnt[GNT_ATS]) begin
            own = OwnAts;
        end else if (gnt[GNT_CPU]) begin
            own = OwnCpu;
        end else if (gnt[GNT_KEY]) begin
            own = OwnKey;
        end
        return own;
    endfunction

endpackage

// File: rtl/io_rr_pick.sv
// Fixed ATS priority over a CPU/KEY pair that alternates on a tie.
module io_rr_pick
    import io_pkg::*;
(
    input  logic      ats_req,
    input  logic      cpu_req,
    input  logic      key_req,
    input  io_owner_t last_owner,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        if (ats_req) begin
            gnt[GNT_ATS] = 1'b1;
        end else if (cpu_req && key_req) begin
            if (last_owner == OwnCpu) begin
                gnt[GNT_KEY] = 1'b1;
            end else begin
                gnt[GNT_CPU] = 1'b1;
            end
        end else if (cpu_req) begin
            gnt[GNT_CPU] = 1'b1;
        end else if (key_req) begin
            gnt[GNT_KEY] = 1'b1;
        end
    end

endmodule

// File: rtl/io_req_arb.sv
// I/O request arbiter: grants ATS/CPU/KEY commands and sequences one I/O operation.
// Optional busy watchdog enabled by defining IO_ARB_TIMEOUT_EN.
module io_req_arb
    import io_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       CLOCK,
    input  logic       rst_n,
    input  logic       READY,
    input  logic       ATS_REQ,
    input  logic       CPU_REQ,
    input  logic [3:0] CPU_CODE,
    input  logic       KEY_REQ,
    input  logic [3:0] KEY_CODE,
    input  logic       ABORT,
    output logic       ATS_GNT,
    output logic       CPU_GNT,
    output logic       KEY_GNT,
    output logic [3:0] OC_SET,
    output logic       OC_CLR,
    output logic       IO_DONE,
    output logic [1:0] IO_OWNER,
    output logic       TIMEOUT
);

    io_state_t  state_q, state_d;
    io_owner_t  owner_q, owner_d;
    io_owner_t  last_q, last_d;
    logic [3:0] code_q, code_d;
    logic [1:0] wcnt_q, wcnt_d;
    logic [2:0] pick, gnt_c;
    logic [3:0] oc_set_c;
    logic       oc_clr_c, done_c;
`ifdef IO_ARB_TIMEOUT_EN
    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic        tmo_c;
`endif

    io_rr_pick u_pick (
        .ats_req   (ATS_REQ),
        .cpu_req   (CPU_REQ),
        .key_req   (KEY_REQ),
        .last_owner(last_q),
        .gnt       (pick)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        code_d   = code_q;
        wcnt_d   = wcnt_q;
        gnt_c    = 3'b000;
        oc_set_c = 4'b0000;
        oc_clr_c = 1'b0;
        done_c   = 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
        busy_cnt_d = busy_cnt_q;
        tmo_c      = 1'b0;
`endif
        if (state_q == StIdle) begin
            // ABORT in IDLE only suppresses the grant
            if (!ABORT && READY && (pick != 3'b000)) begin
                gnt_c   = pick;
                state_d = StIssue;
                owner_d = owner_of(pick);
                code_d  = pick[GNT_ATS] ? ATS_CODE : (pick[GNT_CPU] ? CPU_CODE : KEY_CODE);
                if (!pick[GNT_ATS]) begin
                    last_d = owner_of(pick);
                end
            end
        end else if (ABORT) begin
            oc_clr_c = 1'b1;
            state_d  = StIdle;
            owner_d  = OwnNone;
        end else begin
            case (state_q)
                StIssue: begin
                    wcnt_d = 2'd0;
                    if (code_q == 4'b0000) begin
                        state_d = StDone;
                    end else begin
                        oc_set_c = code_q;
                        state_d  = StWaitb;
                    end
                end
                StWaitb: begin
                    if (!READY) begin
                        state_d = StBusy;
`ifdef IO_ARB_TIMEOUT_EN
                        busy_cnt_d = 16'd0;
`endif
                    end else if (wcnt_q == WAITB_LIMIT - 2'd1) begin
                        state_d = StDone;
                    end else begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end
                StBusy: begin
                    if (READY) begin
                        state_d = StDone;
                    end
`ifdef IO_ARB_TIMEOUT_EN
                    // Counter holds (n-1) during the n-th BUSY cycle
                    else if (busy_cnt_q == TIMEOUT_CYCLES - 16'd1) begin
                        oc_clr_c = 1'b1;
                        tmo_c    = 1'b1;
                        state_d  = StIdle;
                        owner_d  = OwnNone;
                    end else begin
                        busy_cnt_d = busy_cnt_q + 16'd1;
                    end
`endif
                end
                StDone: begin
                    done_c  = 1'b1;
                    state_d = StIdle;
                    owner_d = OwnNone;
                end
                default: begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
            last_q  <= OwnKey;
            code_q  <= 4'b0000;
            wcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            code_q  <= code_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef IO_ARB_TIMEOUT_EN
    always_ff @(posedge CLOCK) begin
        if (!rst_n) begin
            busy_cnt_q <= 16'd0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign TIMEOUT = rst_n & tmo_c;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign TIMEOUT = 1'b0;
`endif

    // Outputs are forced low while reset is held, even before the first reset edge
    assign ATS_GNT  = rst_n & gnt_c[GNT_ATS];
    assign CPU_GNT  = rst_n & gnt_c[GNT_CPU];
    assign KEY_GNT  = rst_n & gnt_c[GNT_KEY];
    assign OC_SET   = rst_n ? oc_set_c : 4'b0000;
    assign OC_CLR   = rst_n & oc_clr_c;
    assign IO_DONE  = rst_n & done_c;
    assign IO_OWNER = rst_n ? owner_q : OwnNone;

endmodule

// File: tb/tb_io_req_arb.sv
// Self-checking bench for io_req_arb; directed scenarios plus randomized traffic vs a model.
`timescale 1ns/1ps
module tb_io_req_arb;

    logic       CLOCK = 1'b0;
    logic       rst_n, READY, ATS_REQ, CPU_REQ, KEY_REQ, ABORT;
    logic [3:0] CPU_CODE, KEY_CODE;
    logic       ATS_GNT, CPU_GNT, KEY_GNT, OC_CLR, IO_DONE, TIMEOUT;
    logic [3:0] OC_SET;
    logic [1:0] IO_OWNER;
    logic [2:0] gnts;
    int checks = 0;
    int errors = 0;

    assign gnts = {KEY_GNT, CPU_GNT, ATS_GNT};

    always #5 CLOCK = ~CLOCK;

    io_req_arb #(.TIMEOUT_CYCLES(16'd8)) dut (
        .CLOCK   (CLOCK),
        .rst_n   (rst_n),
        .READY   (READY),
        .ATS_REQ (ATS_REQ),
        .CPU_REQ (CPU_REQ),
        .CPU_CODE(CPU_CODE),
        .KEY_REQ (KEY_REQ),
        .KEY_CODE(KEY_CODE),
        .ABORT   (ABORT),
        .ATS_GNT (ATS_GNT),
        .CPU_GNT (CPU_GNT),
        .KEY_GNT (KEY_GNT),
        .OC_SET  (OC_SET),
        .OC_CLR  (OC_CLR),
        .IO_DONE (IO_DONE),
        .IO_OWNER(IO_OWNER),
        .TIMEOUT (TIMEOUT)
    );

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle_inputs();
        READY = 1'b1; ATS_REQ = 1'b0; CPU_REQ = 1'b0; KEY_REQ = 1'b0; ABORT = 1'b0;
        CPU_CODE = 4'b0101; KEY_CODE = 4'b1011;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; ATS_REQ = 1'b1; CPU_REQ = 1'b1;
        tick();
        #1;
        checks++; if (gnts !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnts); end
        checks++; if (OC_SET !== 4'b0) begin errors++; $display("FAIL reset_oc_set: got %b expected 0000", OC_SET); end
        checks++; if (OC_CLR !== 1'b0) begin errors++; $display("FAIL reset_oc_clr: got %b expected 0", OC_CLR); end
        checks++; if (IO_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", IO_DONE); end
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", IO_OWNER); end
        checks++; if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", TIMEOUT); end
        ATS_REQ = 1'b0; CPU_REQ = 1'b0; rst_n = 1'b1;
        tick();
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL post_reset_owner: got %0d expected 0", IO_OWNER); end
    endtask

    task automatic test_ats();
        ATS_REQ = 1'b1;
        #1;
        checks++; if (gnts !== 3'b001) begin errors++; $display("FAIL ats_gnt: got %b expected 001", gnts); end
        tick();
        ATS_REQ = 1'b0;
        #1;
        checks++; if (OC_SET !== 4'b1111) begin errors++; $display("FAIL ats_oc_set: got %b expected 1111", OC_SET); end
        checks++; if (IO_OWNER !== 2'd1) begin errors++; $display("FAIL ats_owner: got %0d expected 1", IO_OWNER); end
        for (int k = 2; k <= 13; k++) begin
            tick();
            READY = (k < 12);
            READY = !READY;
            #1;
            checks++; if (IO_DONE !== (k == 13)) begin errors++; $display("FAIL ats_done_k%0d: got %b expected %b", k, IO_DONE, (k == 13)); end
            checks++; if (IO_OWNER !== 2'd1) begin errors++; $display("FAIL ats_owner_k%0d: got %0d expected 1", k, IO_OWNER); end
        end
        tick();
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL ats_owner_idle: got %0d expected 0", IO_OWNER); end
    endtask

    task automatic test_alternate();
        logic [2:0] exp_g [3];
        logic [3:0] exp_c [3];
        exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b010;
        exp_c[0] = 4'b0101; exp_c[1] = 4'b1011; exp_c[2] = 4'b0101;
        do_reset();
        CPU_REQ = 1'b1; KEY_REQ = 1'b1; CPU_CODE = 4'b0101; KEY_CODE = 4'b1011;
        for (int op = 0; op < 3; op++) begin
            #1;
            checks++; if (gnts !== exp_g[op]) begin errors++; $display("FAIL alt_gnt_%0d: got %b expected %b", op, gnts, exp_g[op]); end
            tick();
            #1;
            checks++; if (OC_SET !== exp_c[op]) begin errors++; $display("FAIL alt_code_%0d: got %b expected %b", op, OC_SET, exp_c[op]); end
            tick(); tick(); tick();
            checks++; if (IO_DONE !== 1'b1) begin errors++; $display("FAIL alt_done_%0d: got %b expected 1", op, IO_DONE); end
            if (op == 2) begin CPU_REQ = 1'b0; KEY_REQ = 1'b0; end
            tick();
        end
    endtask

    task automatic test_null_code();
        CPU_CODE = 4'b0000; CPU_REQ = 1'b1;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL null_gnt: got %b expected 010", gnts); end
        tick();
        CPU_REQ = 1'b0;
        #1;
        checks++; if (OC_SET !== 4'b0000) begin errors++; $display("FAIL null_oc_set: got %b expected 0000", OC_SET); end
        checks++; if (IO_DONE !== 1'b0) begin errors++; $display("FAIL null_done_early: got %b expected 0", IO_DONE); end
        tick();
        checks++; if (IO_DONE !== 1'b1) begin errors++; $display("FAIL null_done: got %b expected 1", IO_DONE); end
        checks++; if (IO_OWNER !== 2'd2) begin errors++; $display("FAIL null_owner: got %0d expected 2", IO_OWNER); end
        tick();
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL null_owner_idle: got %0d expected 0", IO_OWNER); end
        CPU_CODE = 4'b0101;
    endtask

    task automatic test_abort();
        ATS_REQ = 1'b1;
        tick();
        ATS_REQ = 1'b0;
        tick();
        READY = 1'b0;
        tick(); tick(); tick();
        ABORT = 1'b1;
        #1;
        checks++; if (OC_CLR !== 1'b1) begin errors++; $display("FAIL abort_oc_clr: got %b expected 1", OC_CLR); end
        checks++; if (IO_DONE !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", IO_DONE); end
        tick();
        ABORT = 1'b0;
        #1;
        checks++; if (OC_CLR !== 1'b0) begin errors++; $display("FAIL abort_oc_clr_off: got %b expected 0", OC_CLR); end
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL abort_owner: got %0d expected 0", IO_OWNER); end
        for (int k = 0; k < 4; k++) begin
            tick();
            READY = (k == 3);
            #1;
            checks++; if (IO_DONE !== 1'b0) begin errors++; $display("FAIL abort_no_done_%0d: got %b expected 0", k, IO_DONE); end
        end
        ABORT = 1'b1; CPU_REQ = 1'b1;
        #1;
        checks++; if (gnts !== 3'b000) begin errors++; $display("FAIL abort_idle_gnt: got %b expected 000", gnts); end
        checks++; if (OC_CLR !== 1'b0) begin errors++; $display("FAIL abort_idle_clr: got %b expected 0", OC_CLR); end
        tick();
        ABORT = 1'b0; CPU_REQ = 1'b0;
        #1;
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL abort_idle_owner: got %0d expected 0", IO_OWNER); end
        KEY_REQ = 1'b1; READY = 1'b0;
        #1;
        checks++; if (gnts !== 3'b000) begin errors++; $display("FAIL notready_gnt: got %b expected 000", gnts); end
        tick();
        KEY_REQ = 1'b0; READY = 1'b1;
        #1;
        checks++; if (gnts !== 3'b000) begin errors++; $display("FAIL dropped_req_gnt: got %b expected 000", gnts); end
        tick();
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL dropped_req_owner: got %0d expected 0", IO_OWNER); end
    endtask

    task automatic test_timeout();
        ATS_REQ = 1'b1;
        tick();
        ATS_REQ = 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
        for (int k = 2; k <= 11; k++) begin
            tick();
            READY = 1'b0;
            #1;
            checks++; if (TIMEOUT !== (k == 10)) begin errors++; $display("FAIL tmo_k%0d: got %b expected %b", k, TIMEOUT, (k == 10)); end
            checks++; if (OC_CLR !== (k == 10)) begin errors++; $display("FAIL tmo_clr_k%0d: got %b expected %b", k, OC_CLR, (k == 10)); end
            checks++; if (IO_DONE !== 1'b0) begin errors++; $display("FAIL tmo_done_k%0d: got %b expected 0", k, IO_DONE); end
        end
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL tmo_owner: got %0d expected 0", IO_OWNER); end
        READY = 1'b1;
        tick();
`else
        for (int k = 2; k <= 30; k++) begin
            tick();
            READY = 1'b0;
            #1;
            checks++; if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL notmo_k%0d: got %b expected 0", k, TIMEOUT); end
            checks++; if (IO_OWNER !== 2'd1) begin errors++; $display("FAIL notmo_owner_k%0d: got %0d expected 1", k, IO_OWNER); end
            checks++; if (IO_DONE !== 1'b0) begin errors++; $display("FAIL notmo_done_k%0d: got %b expected 0", k, IO_DONE); end
        end
        tick();
        READY = 1'b1;
        tick();
        checks++; if (IO_DONE !== 1'b1) begin errors++; $display("FAIL notmo_release_done: got %b expected 1", IO_DONE); end
        tick();
`endif
    endtask

    task automatic test_reset_mid_busy();
        CPU_REQ = 1'b1;
        tick();
        CPU_REQ = 1'b0;
        tick();
        READY = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++; if (OC_CLR !== 1'b0) begin errors++; $display("FAIL rst_busy_clr: got %b expected 0", OC_CLR); end
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL rst_busy_owner: got %0d expected 0", IO_OWNER); end
        tick();
        rst_n = 1'b1; READY = 1'b1;
        #1;
        checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL rst_after_owner: got %0d expected 0", IO_OWNER); end
        checks++; if (IO_DONE !== 1'b0) begin errors++; $display("FAIL rst_after_done: got %b expected 0", IO_DONE); end
        checks++; if (OC_SET !== 4'b0) begin errors++; $display("FAIL rst_after_oc_set: got %b expected 0000", OC_SET); end
        tick();
        CPU_REQ = 1'b1; KEY_REQ = 1'b1;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL rst_tie_gnt: got %b expected 010", gnts); end
        tick();
        CPU_REQ = 1'b0; KEY_REQ = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic       a, c, k;
        logic [3:0] cc, kc, exp_code;
        logic [1:0] exp_own, last_m;
        logic [2:0] exp_g;
        int         d, len, done_k;
        do_reset();
        last_m = 2'd3;
        for (int t = 0; t < 40; t++) begin
            a  = ($urandom_range(0, 3) == 0);
            c  = 1'($urandom_range(0, 1));
            k  = 1'($urandom_range(0, 1));
            cc = 4'($urandom);
            kc = 4'($urandom);
            if ($urandom_range(0, 4) == 0) cc = 4'b0000;
            if ($urandom_range(0, 4) == 0) kc = 4'b0000;
            d   = int'($urandom_range(0, 2));
            len = int'($urandom_range(1, 6));
            ATS_REQ = a; CPU_REQ = c; KEY_REQ = k; CPU_CODE = cc; KEY_CODE = kc;
            if (a) exp_own = 2'd1;
            else if (c && k) exp_own = (last_m == 2'd2) ? 2'd3 : 2'd2;
            else if (c) exp_own = 2'd2;
            else if (k) exp_own = 2'd3;
            else exp_own = 2'd0;
            case (exp_own)
                2'd1: begin exp_g = 3'b001; exp_code = 4'b1111; end
                2'd2: begin exp_g = 3'b010; exp_code = cc; end
                2'd3: begin exp_g = 3'b100; exp_code = kc; end
                default: begin exp_g = 3'b000; exp_code = 4'b0000; end
            endcase
            if (exp_own >= 2'd2) last_m = exp_own;
            #1;
            checks++; if (gnts !== exp_g) begin errors++; $display("FAIL rnd_gnt_%0d: got %b expected %b", t, gnts, exp_g); end
            tick();
            ATS_REQ = 1'b0; CPU_REQ = 1'b0; KEY_REQ = 1'b0;
            #1;
            checks++; if (IO_OWNER !== exp_own) begin errors++; $display("FAIL rnd_owner_%0d: got %0d expected %0d", t, IO_OWNER, exp_own); end
            if (exp_own != 2'd0) begin
                checks++; if (OC_SET !== exp_code) begin errors++; $display("FAIL rnd_code_%0d: got %b expected %b", t, OC_SET, exp_code); end
                done_k = (exp_code == 4'b0000) ? 2 : ((d == 2) ? 4 : 3 + d + len);
                for (int kk = 2; kk <= done_k; kk++) begin
                    tick();
                    READY = !(exp_code != 4'b0000 && d < 2 && kk >= 2 + d && kk < 2 + d + len);
                    #1;
                    checks++; if (IO_DONE !== (kk == done_k)) begin errors++; $display("FAIL rnd_done_%0d_k%0d: got %b expected %b", t, kk, IO_DONE, (kk == done_k)); end
                    checks++; if (IO_OWNER !== exp_own) begin errors++; $display("FAIL rnd_own_%0d_k%0d: got %0d expected %0d", t, kk, IO_OWNER, exp_own); end
                end
                tick();
                READY = 1'b1;
                #1;
                checks++; if (IO_OWNER !== 2'd0) begin errors++; $display("FAIL rnd_idle_%0d: got %0d expected 0", t, IO_OWNER); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ats();
        test_alternate();
        test_null_code();
        test_abort();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
